response_uart_tx: RTL and testbench

- Downstream stage of the sensor decoder facade; consumes its `finished` / `response_code` / `response` outputs.
- Queues each result pair in a small FIFO and serializes it to the host as UART 8N1 frames: code byte first, then response byte.
- Decouples the decoder's one-cycle `finished` pulse from the much slower serial link. Continuous-monitoring results are never lost unless the FIFO overflows.

---
 rtl/sensor_link_pkg.sv | 41 ++++
 rtl/response_uart_tx_if.sv | 15 +
 rtl/uart_byte_tx.sv | 115 +++++++++++
 rtl/response_uart_tx.sv | 144 ++++++++++++++
 tb/tb_response_uart_tx.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sensor_link_pkg.sv
// Shared definitions for the sensor decoder link: response codes, payload
// values, the byte transmitter state encoding and the entry checksum helper.
package sensor_link_pkg;

  // Response codes produced by the decoder facade
  localparam logic [7:0] RC_STATUS        = 8'h10;
  localparam logic [7:0] RC_TEMP          = 8'h13;
  localparam logic [7:0] RC_HUM           = 8'h14;
  localparam logic [7:0] RC_TEMP_LOOP_ON  = 8'h15;
  localparam logic [7:0] RC_HUM_LOOP_ON   = 8'h16;
  localparam logic [7:0] RC_TEMP_LOOP_OFF = 8'h17;
  localparam logic [7:0] RC_HUM_LOOP_OFF  = 8'h18;
  localparam logic [7:0] RC_INVALID_CMD   = 8'hEC;

  // Payload constants
  localparam logic [7:0] PL_SENSOR_OK     = 8'h11;
  localparam logic [7:0] PL_SENSOR_FAIL   = 8'h12;
  localparam logic [7:0] PL_CONFIRM       = 8'hCA;
  localparam logic [7:0] PL_INVALID_ACTION = 8'hEA;

  // Serial byte transmitter states
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // One queued result
  typedef struct packed {
    logic [7:0] code;
    logic [7:0] resp;
  } result_t;

  // Trailing integrity byte of an entry
  function automatic logic [7:0] entry_checksum(input logic [7:0] code,
                                                input logic [7:0] resp);
    return code ^ resp;
  endfunction

endpackage

// File: rtl/response_uart_tx_if.sv
// Result/serial bundle between the decoder facade (master) and the
// response UART transmitter (slave).
interface response_uart_tx_if;
  logic       finished;
  logic [7:0] response_code;
  logic [7:0] response;
  logic       tx;
  logic       busy;
  logic       overflow;

  modport master (output finished, output response_code, output response,
                  input tx, input busy, input overflow);
  modport slave  (input finished, input response_code, input response,
                  output tx, output busy, output overflow);
endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer. A byte is accepted on load_i whenever ready_o is high:
// in IDLE, or on the last cycle of STOP so back-to-back bytes need no gap.
module uart_byte_tx
  import sensor_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic      clock_i,
  input  logic      reset_i,
  input  logic      load_i,
  input  logic [7:0] byte_i,
  output logic      ready_o,
  output tx_state_t state_o,
  output logic      tx_o
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_t         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              baud_last_s;

  assign baud_last_s = (baud_q == BAUD_LAST);
  assign ready_o     = (state_q == TX_IDLE) || ((state_q == TX_STOP) && baud_last_s);
  assign state_o     = state_q;
  assign tx_o        = tx_q;

  // State, counters, data shifter and the registered line level
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Bit timing and line value for the next cycle
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      TX_IDLE: begin
        baud_d = '0;
        if (load_i) begin
          state_d = TX_START;
          shift_d = byte_i;
          tx_d    = 1'b0;
        end else begin
          tx_d = 1'b1;
        end
      end
      TX_START: begin
        if (baud_last_s) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = TX_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      TX_DATA: begin
        if (baud_last_s) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      TX_STOP: begin
        if (baud_last_s) begin
          baud_d = '0;
          if (load_i) begin
            state_d = TX_START;
            shift_d = byte_i;
            tx_d    = 1'b0;
          end else begin
            state_d = TX_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = TX_IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/response_uart_tx.sv
// Response UART transmitter: edge-detects the decoder's finished strobe,
// queues {code, response} pairs and sends each as consecutive 8N1 bytes.
// Optional macro RESPONSE_UART_TX_CHECKSUM_EN appends code^response as a
// third byte per entry.
module response_uart_tx
  import sensor_link_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input logic               clock,
  input logic               reset,
  response_uart_tx_if.slave bus
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CNT_W        = PTR_W + 1;
`ifdef RESPONSE_UART_TX_CHECKSUM_EN
  localparam int NUM_BYTES    = 3;
`else
  localparam int NUM_BYTES    = 2;
`endif
  // Bytes still to follow the code byte, held in a right-shifting holder
  localparam int HOLD_W       = 8 * (NUM_BYTES - 1);
  localparam logic [1:0] LAST_IDX = 2'(NUM_BYTES - 1);

  if (CLKS_PER_BIT < 2) begin : g_cpb_check
    $error("response_uart_tx: CLOCK_FREQ/BAUD_RATE must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
    $error("response_uart_tx: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  logic             finished_q;
  result_t          mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [HOLD_W-1:0] holder_q, holder_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic             overflow_q;

  logic      rise_s, full_s, pop_s, push_s, drop_s, next_byte_s, load_s;
  logic [7:0] byte_s;
  result_t   head_s;
  logic      tx_ready_s, tx_line_s;
  tx_state_t tx_state_s;

  assign head_s      = mem_q[rd_ptr_q];
  assign rise_s      = bus.finished && !finished_q;
  assign full_s      = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop_s       = (tx_state_s == TX_IDLE) && (count_q != '0);
  // A full FIFO still takes the push when the head leaves in the same cycle
  assign push_s      = rise_s && (!full_s || pop_s);
  assign drop_s      = rise_s && full_s && !pop_s;
  assign next_byte_s = (tx_state_s == TX_STOP) && tx_ready_s && (byte_idx_q != LAST_IDX);
  assign load_s      = pop_s || next_byte_s;
  assign byte_s      = pop_s ? head_s.code : holder_q[7:0];

  assign bus.tx       = tx_line_s;
  assign bus.busy     = (tx_state_s != TX_IDLE) || (count_q != '0);
  assign bus.overflow = overflow_q;

  // Edge detect register and one-cycle drop indication
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      finished_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      finished_q <= bus.finished;
      overflow_q <= drop_s;
    end
  end

  // Result FIFO storage, pointers and occupancy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= {bus.response_code, bus.response};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Remaining-byte holder and position within the current entry
  always_comb begin
    holder_d   = holder_q;
    byte_idx_d = byte_idx_q;
    if (pop_s) begin
`ifdef RESPONSE_UART_TX_CHECKSUM_EN
      holder_d = {entry_checksum(head_s.code, head_s.resp), head_s.resp};
`else
      holder_d = head_s.resp;
`endif
      byte_idx_d = 2'd0;
    end else if (next_byte_s) begin
      holder_d   = HOLD_W'(holder_q >> 8);
      byte_idx_d = byte_idx_q + 2'd1;
    end else begin
      holder_d   = holder_q;
      byte_idx_d = byte_idx_q;
    end
  end

  // Sequencing registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      holder_q   <= '0;
      byte_idx_q <= 2'd0;
    end else begin
      holder_q   <= holder_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clock_i(clock),
    .reset_i(reset),
    .load_i (load_s),
    .byte_i (byte_s),
    .ready_o(tx_ready_s),
    .state_o(tx_state_s),
    .tx_o   (tx_line_s)
  );

endmodule

// File: tb/tb_response_uart_tx.sv
// Self-checking bench for response_uart_tx: directed table, hand-written
// corner sequences and randomized pulses against an entry-level timing model
// and a UART line decoder.
module tb_response_uart_tx;

  localparam int CPB   = 10;
  localparam int DEPTH = 4;
`ifdef RESPONSE_UART_TX_CHECKSUM_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif
  localparam int FRAME = NB * 10 * CPB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  response_uart_tx_if bus_if();

  response_uart_tx #(
    .CLOCK_FREQ(1000),
    .BAUD_RATE (100),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus_if)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [15:0] m_fifo[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  rx_q[$];
  int   e = 0;
  int   tx_end = 0;
  int   last_pop = 0;
  logic m_prev = 1'b0;
  int   ovf_seen = 0;

  typedef struct {
    logic [7:0] code;
    logic [7:0] resp;
    int         hold;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Line decoder: sample mid-bit, check the stop bit, collect bytes
  initial begin : monitor
    int k;
    logic in_frame;
    logic [7:0] sh;
    in_frame = 1'b0;
    k = 0;
    sh = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 1'b0;
      end else if (!in_frame) begin
        if (bus_if.tx == 1'b0) begin
          in_frame = 1'b1;
          k = 0;
        end
      end else begin
        k++;
        if (k >= CPB + CPB / 2 && k < 9 * CPB + CPB / 2 && ((k - CPB / 2) % CPB) == 0)
          sh = {bus_if.tx, sh[7:1]};
        if (k == 9 * CPB + CPB / 2) begin
          chk("stop_bit", bus_if.tx, 1);
          rx_q.push_back(sh);
          in_frame = 1'b0;
        end
      end
    end
  end

  // One clock: drive inputs, advance the model, check overflow and busy
  task automatic tick(input logic f, input logic [7:0] c, input logic [7:0] r);
    logic pop, rise, exp_ovf;
    logic [15:0] ent;
    bus_if.finished = f;
    bus_if.response_code = c;
    bus_if.response = r;
    e++;
    pop = (m_fifo.size() > 0) && (e > tx_end);
    rise = f && !m_prev;
    m_prev = f;
    exp_ovf = 1'b0;
    if (pop) begin
      ent = m_fifo.pop_front();
      exp_q.push_back(ent[15:8]);
      exp_q.push_back(ent[7:0]);
`ifdef RESPONSE_UART_TX_CHECKSUM_EN
      exp_q.push_back(ent[15:8] ^ ent[7:0]);
`endif
      last_pop = e;
      tx_end = e + FRAME;
    end
    if (rise) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back({c, r});
      else exp_ovf = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    if (bus_if.overflow) ovf_seen++;
    chk("overflow", bus_if.overflow, exp_ovf);
    chk("busy", bus_if.busy, (e < tx_end) || (m_fifo.size() > 0));
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((e <= tx_end + 1 || m_fifo.size() > 0) && guard < 5000) begin
      tick(1'b0, 8'h00, 8'h00);
      guard++;
    end
    chk("drain_timeout", guard < 5000, 1);
  endtask

  task automatic check_stream(input string name);
    chk({name, "_count"}, rx_q.size(), exp_q.size());
    while (exp_q.size() > 0 && rx_q.size() > 0)
      chk(name, rx_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    rx_q.delete();
  endtask

  initial begin : stim
    logic prev_tx;
    int toggles;
    logic [7:0] c, r;
    int gap, hold;

    tbl[0] = '{8'h13, 8'h19, 1, 8'h13, 8'h19, 8'h0A};
    tbl[1] = '{8'h10, 8'h11, 5, 8'h10, 8'h11, 8'h01};
    tbl[2] = '{8'hEC, 8'hEA, 2, 8'hEC, 8'hEA, 8'h06};
    tbl[3] = '{8'h17, 8'hCA, 1, 8'h17, 8'hCA, 8'hDD};
    tbl[4] = '{8'h00, 8'hFF, 3, 8'h00, 8'hFF, 8'hFF};
    tbl[5] = '{8'h14, 8'h3C, 1, 8'h14, 8'h3C, 8'h28};

    bus_if.finished = 1'b0;
    bus_if.response_code = 8'h00;
    bus_if.response = 8'h00;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset_tx", bus_if.tx, 1);
    chk("reset_busy", bus_if.busy, 0);
    chk("reset_overflow", bus_if.overflow, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single pulse: line falls two cycles after the strobe
    tick(1'b1, 8'h13, 8'h19);
    chk("tx_before_pop", bus_if.tx, 1);
    tick(1'b0, 8'h00, 8'h00);
    chk("tx_fall_latency", bus_if.tx, 0);
    drain();
    check_stream("single");

    // Directed table, including a held-high strobe
    ovf_seen = 0;
    for (int i = 0; i < 6; i++) begin
      for (int h = 0; h < tbl[i].hold; h++) tick(1'b1, tbl[i].code, tbl[i].resp);
      tick(1'b0, 8'h00, 8'h00);
      drain();
      chk("tbl_nbytes", rx_q.size(), NB);
      if (rx_q.size() == NB) begin
        chk("tbl_code", rx_q[0], tbl[i].b0);
        chk("tbl_resp", rx_q[1], tbl[i].b1);
`ifdef RESPONSE_UART_TX_CHECKSUM_EN
        chk("tbl_chk", rx_q[2], tbl[i].b2);
`endif
      end
      check_stream("tbl_model");
    end
    chk("tbl_no_overflow", ovf_seen, 0);

    // Six pulses three cycles apart: one overflow, five entries
    ovf_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 8'(8'h20 + i), 8'(8'h40 + i));
      tick(1'b0, 8'h00, 8'h00);
      tick(1'b0, 8'h00, 8'h00);
    end
    chk("six_overflow_pulses", ovf_seen, 1);
    drain();
    chk("six_entries_bytes", rx_q.size(), 5 * NB);
    check_stream("six");

    // Full FIFO, push lands on the pop cycle
    ovf_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 8'(8'h60 + i), 8'(8'h80 + i));
      tick(1'b0, 8'h00, 8'h00);
      tick(1'b0, 8'h00, 8'h00);
    end
    chk("fill_count", m_fifo.size(), DEPTH);
    while (e + 1 <= tx_end) tick(1'b0, 8'h00, 8'h00);
    tick(1'b1, 8'h77, 8'h88);
    tick(1'b0, 8'h00, 8'h00);
    chk("pop_push_no_overflow", ovf_seen, 0);
    drain();
    check_stream("pop_push");

    // Randomized pulses against the model
    for (int i = 0; i < 30; i++) begin
      gap = $urandom_range(0, 260);
      hold = $urandom_range(1, 3);
      c = 8'($urandom);
      r = 8'($urandom);
      for (int g = 0; g < gap; g++) tick(1'b0, 8'h00, 8'h00);
      for (int h = 0; h < hold; h++) tick(1'b1, c, r);
    end
    tick(1'b0, 8'h00, 8'h00);
    drain();
    check_stream("random");

    // Reset during bit 4 of the response byte
    tick(1'b1, 8'h15, 8'hEA);
    tick(1'b0, 8'h00, 8'h00);
    while (e < last_pop + 10 * CPB + 5 * CPB + CPB / 2) tick(1'b0, 8'h00, 8'h00);
    chk("bit4_low_before_reset", bus_if.tx, 0);
    #2 rst = 1'b1;
    #1;
    chk("tx_async_reset", bus_if.tx, 1);
    chk("busy_async_reset", bus_if.busy, 0);
    m_fifo.delete();
    exp_q.delete();
    tx_end = 0;
    m_prev = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rx_q.delete();
    prev_tx = bus_if.tx;
    toggles = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1'b0, 8'h00, 8'h00);
      if (bus_if.tx !== prev_tx) toggles++;
      prev_tx = bus_if.tx;
    end
    chk("no_tx_edges_after_reset", toggles, 0);
    chk("no_bytes_after_reset", rx_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
